// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//   Parametrised multi-port integer register file with optional same-cycle
//   write-to-read bypass and a per-register busy scoreboard.
//
//   Register 0 is hardwired to zero and can never be marked busy.
//   When several enabled write ports target the same register, the
//   highest-index port wins. This applies both to the committed value and to
//   the bypassed read value.
//
// Ports
//   clk_in        : clock; all state updates on the rising edge
//   rst_in        : asynchronous active-high reset; clears all registers and busy bits
//   rs_in         : packed read register numbers, slice r belongs to read port r
//   reg_data_out  : packed read data, slice r belongs to read port r
//   reg_busy_out  : busy flag of the register addressed by each read port
//   rd_in         : packed write register numbers, slice w belongs to write port w
//   data_write    : packed write data, slice w belongs to write port w
//   write_en      : per-write-port enable
//   busy_set_en   : mark register busy_set_rd as having a pending producer
//   busy_set_rd   : register number to mark busy
// -----------------------------------------------------------------------------
module reg_file_mp #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5,
    parameter int NUM_READ_PORTS     = 2,
    parameter int NUM_WRITE_PORTS    = 2,
    parameter int BYPASS_EN          = 1
) (
    input  logic                                                clk_in,
    input  logic                                                rst_in,
    input  logic [NUM_READ_PORTS*REG_MEM_DEPTH_POW-1:0]         rs_in,
    output logic [NUM_READ_PORTS*(1<<REG_DATA_WIDTH_POW)-1:0]   reg_data_out,
    output logic [NUM_READ_PORTS-1:0]                           reg_busy_out,
    input  logic [NUM_WRITE_PORTS*REG_MEM_DEPTH_POW-1:0]        rd_in,
    input  logic [NUM_WRITE_PORTS*(1<<REG_DATA_WIDTH_POW)-1:0]  data_write,
    input  logic [NUM_WRITE_PORTS-1:0]                          write_en,
    input  logic                                                busy_set_en,
    input  logic [REG_MEM_DEPTH_POW-1:0]                        busy_set_rd
);

    localparam int DW    = 1 << REG_DATA_WIDTH_POW;
    localparam int AW    = REG_MEM_DEPTH_POW;
    localparam int DEPTH = 1 << REG_MEM_DEPTH_POW;

    // Architectural state. Flops are used rather than RAM because reset must
    // clear every entry asynchronously.
    logic [DEPTH-1:0][DW-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]         busy_q, busy_d;

    // Per-write-port unpacked views. A write to register 0 is never valid.
    logic [AW-1:0]              wr_addr  [NUM_WRITE_PORTS];
    logic [DW-1:0]              wr_data  [NUM_WRITE_PORTS];
    logic [NUM_WRITE_PORTS-1:0] wr_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WRITE_PORTS; gi++) begin : g_wr
            assign wr_addr[gi]  = rd_in[gi*AW +: AW];
            assign wr_data[gi]  = data_write[gi*DW +: DW];
            assign wr_valid[gi] = write_en[gi] && (rd_in[gi*AW +: AW] != '0);
        end
    endgenerate

    // Next state. Ports are applied in ascending order, so the highest-index
    // port overrides lower ones on the same register. A busy set is applied
    // after the clears so that a new producer supersedes a completing one.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (wr_valid[w]) begin
                regs_d[wr_addr[w]] = wr_data[w];
                busy_d[wr_addr[w]] = 1'b0;
            end
        end
        if (busy_set_en && (busy_set_rd != '0)) begin
            busy_d[busy_set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: combinational, fully independent of each other.
    generate
        for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
            logic [AW-1:0] rs;
            logic [DW-1:0] rdata;
            logic          rbusy;

            assign rs = rs_in[gi*AW +: AW];

            always_comb begin
                rdata = regs_q[rs];
                rbusy = busy_q[rs];
                // A bypassed value comes from the completing producer, so the
                // register is no longer waiting on it this cycle.
                if (BYPASS_EN != 0) begin
                    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                        if (wr_valid[w] && (wr_addr[w] == rs)) begin
                            rdata = wr_data[w];
                            rbusy = 1'b0;
                        end
                    end
                end
                // During reset the stored state is already zero, but bypass
                // must also be suppressed so the outputs read zero.
                if ((rs == '0) || rst_in) begin
                    rdata = '0;
                    rbusy = 1'b0;
                end
            end

            assign reg_data_out[gi*DW +: DW] = rdata;
            assign reg_busy_out[gi]          = rbusy;
        end
    endgenerate

endmodule
